// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and constants for the clock-source switch controller.
package clk_switch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    localparam int SETTLE_DEF = 8;
    localparam int DWELL_DEF  = 16;
    localparam int TMR_W      = 8;

endpackage

// File: rtl/clk_switch_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cycle_timer
    import clk_switch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitchless 2:1 clock mux select: settle after a change, then dwell.
// Define CLK_SWITCH_CTRL_SW_CNT_EN to enable the saturating completed-switch counter.
//
// state  | meaning
// IDLE   | ready for a request; no-op and reject answered from here
// SETTLE | sel changed, waiting for the mux to settle before confirming
// DWELL  | switch confirmed, holding off further requests
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int DWELL_CYCLES  = DWELL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    input  logic [1:0] src_ok,
    output logic       sel,
    output logic       cur_sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] sw_cnt
);

    // done is registered off expiry, so settle spans SETTLE_CYCLES+1 edges;
    // the dwell count includes the done cycle itself, hence the minus one.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] DWELL_LD  = TMR_W'(DWELL_CYCLES - 1);

    state_t           state_q;
    logic             sel_q, cur_sel_q, busy_q, done_q, err_q, ready_q;
    logic             noop_pend_q, rej_pend_q;
    logic             tmr_load, tmr_expired;
    logic [TMR_W-1:0] tmr_val;
    logic             accept, is_noop, is_rej, go;

    assign accept  = req_valid && ready_q;
    assign is_noop = (req_sel == cur_sel_q);
    assign is_rej  = !is_noop && !src_ok[req_sel];
    assign go      = accept && !is_noop && !is_rej;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_q == ST_IDLE && go) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
        end else if (state_q == ST_SETTLE && tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = DWELL_LD;
        end
    end

    cycle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            cur_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            noop_pend_q <= 1'b0;
            rej_pend_q  <= 1'b0;
        end else begin
            done_q      <= noop_pend_q;
            err_q       <= rej_pend_q;
            noop_pend_q <= 1'b0;
            rej_pend_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (is_noop) begin
                            noop_pend_q <= 1'b1;
                        end else if (is_rej) begin
                            rej_pend_q <= 1'b1;
                        end else begin
                            sel_q   <= req_sel;
                            state_q <= ST_SETTLE;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expired) begin
                        done_q    <= 1'b1;
                        cur_sel_q <= sel_q;
                        state_q   <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (tmr_expired) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_SWITCH_CTRL_SW_CNT_EN
    logic [7:0] sw_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt_q <= '0;
        end else if (state_q == ST_SETTLE && tmr_expired && sw_cnt_q != 8'hFF) begin
            sw_cnt_q <= sw_cnt_q + 8'd1;
        end
    end

    assign sw_cnt = sw_cnt_q;
`else
    assign sw_cnt = '0;
`endif

    assign req_ready = ready_q;
    assign sel       = sel_q;
    assign cur_sel   = cur_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with default SETTLE/DWELL parameters.
module tb_clk_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic [1:0] src_ok;
    logic       sel;
    logic       cur_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] sw_cnt;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int both_seen = 0;
    int d0, e0;
    int exp_cnt;

    always #5 clk = ~clk;

    clk_switch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .src_ok    (src_ok),
        .sel       (sel),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sw_cnt    (sw_cnt)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (err === 1'b1) err_seen++;
        if (done === 1'b1 && err === 1'b1) both_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        src_ok    = 2'b11;

        // reset state
        #2;
        chk("rst_sel", sel, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sw_cnt", sw_cnt, 0);
        #18;
        rst = 1'b0;
        tick(1);
        chk("rel_ready", req_ready, 1);
        chk("rel_sel", sel, 0);
        chk("rel_done", done, 0);
        chk("rel_err", err, 0);

        // no-op request
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick(1);
        chk("noop_done_n", done, 0);
        chk("noop_sel_n", sel, 0);
        chk("noop_ready_n", req_ready, 1);
        chk("noop_busy_n", busy, 0);
        req_valid = 1'b0;
        tick(1);
        chk("noop_done_n1", done, 1);
        chk("noop_err_n1", err, 0);
        chk("noop_sel_n1", sel, 0);
        tick(1);
        chk("noop_done_n2", done, 0);

        // rejected request: target clock absent
        src_ok    = 2'b01;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick(1);
        chk("rej_err_n", err, 0);
        chk("rej_sel_n", sel, 0);
        chk("rej_busy_n", busy, 0);
        req_valid = 1'b0;
        tick(1);
        chk("rej_err_n1", err, 1);
        chk("rej_done_n1", done, 0);
        chk("rej_sel_n1", sel, 0);
        tick(1);
        chk("rej_err_n2", err, 0);
        src_ok = 2'b11;

        // reset in the middle of SETTLE
        d0 = done_seen;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick(1);
        chk("mid_sel_n", sel, 1);
        chk("mid_busy_n", busy, 1);
        req_valid = 1'b0;
        tick(3);
        chk("mid_sel_n3", sel, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_async_sel", sel, 0);
        chk("mid_async_cur", cur_sel, 0);
        chk("mid_async_busy", busy, 0);
        chk("mid_async_ready", req_ready, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_sel", sel, 0);
        chk("mid_rel_busy", busy, 0);
        tick(12);
        chk("mid_no_done", done_seen - d0, 0);

        // real switch 0->1 with a second request (1->0) held through SETTLE and DWELL
        d0 = done_seen;
        e0 = err_seen;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick(1);
        chk("sw_sel_n", sel, 1);
        chk("sw_busy_n", busy, 1);
        chk("sw_ready_n", req_ready, 0);
        chk("sw_cur_n", cur_sel, 0);
        req_valid = 1'b0;
        tick(2);
        req_sel   = 1'b0;
        req_valid = 1'b1;
        tick(6);
        chk("sw_done_n8", done, 0);
        chk("sw_sel_n8", sel, 1);
        chk("sw_ready_n8", req_ready, 0);
        tick(1);
        chk("sw_done_n9", done, 1);
        chk("sw_cur_n9", cur_sel, 1);
        chk("sw_sel_n9", sel, 1);
        src_ok = 2'b00;
        tick(5);
        chk("dw_sel_n14", sel, 1);
        chk("dw_err_n14", err, 0);
        chk("dw_busy_n14", busy, 1);
        src_ok = 2'b11;
        tick(10);
        chk("dw_ready_n24", req_ready, 0);
        chk("dw_sel_n24", sel, 1);
        tick(1);
        chk("dw_ready_n25", req_ready, 1);
        chk("dw_busy_n25", busy, 0);
        chk("dw_sel_n25", sel, 1);
        tick(1);
        chk("b2b_sel_n26", sel, 0);
        chk("b2b_busy_n26", busy, 1);
        chk("b2b_ready_n26", req_ready, 0);
        req_valid = 1'b0;
        tick(8);
        chk("b2b_done_n34", done, 0);
        chk("b2b_cur_n34", cur_sel, 1);
        tick(1);
        chk("b2b_done_n35", done, 1);
        chk("b2b_cur_n35", cur_sel, 0);
        tick(15);
        chk("b2b_ready_n50", req_ready, 0);
        tick(1);
        chk("b2b_ready_n51", req_ready, 1);
        chk("b2b_done_count", done_seen - d0, 2);
        chk("b2b_err_count", err_seen - e0, 0);

`ifdef CLK_SWITCH_CTRL_SW_CNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        chk("cnt_after_b2b", sw_cnt, exp_cnt);

        // 300 alternating switches: counter saturation (or stays zero)
        for (int i = 0; i < 300; i++) begin
            req_sel   = (i % 2 == 0) ? 1'b1 : 1'b0;
            req_valid = 1'b1;
            tick(1);
            req_valid = 1'b0;
            tick(25);
`ifdef CLK_SWITCH_CTRL_SW_CNT_EN
            if (exp_cnt < 255) exp_cnt++;
`endif
            chk("cnt_loop", sw_cnt, exp_cnt);
        end
        chk("cnt_final_ready", req_ready, 1);
        chk("cnt_final_cur", cur_sel, 0);
`ifdef CLK_SWITCH_CTRL_SW_CNT_EN
        chk("cnt_final", sw_cnt, 255);
`else
        chk("cnt_final", sw_cnt, 0);
`endif
        chk("done_err_overlap", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
